// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the alu_wb_stage execute->writeback boundary stage.
// Default widths and the skid-buffer occupancy encoding live here.
package alu_wb_stage_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_STALL_W = 16;

  // Occupancy of the 2-entry skid buffer; the encoding is the entry count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_wb_stage_skid_buf.sv
// alu_skid_buf: 2-entry in-order skid buffer (head/tail registers + count FSM).
// Both ready and valid are decoded from the count register only.
module alu_skid_buf
  import alu_wb_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_r;
  buf_state_e   state_next_s;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         push_s;
  logic         pop_s;

  assign push_s   = in_valid & in_ready;
  assign pop_s    = out_valid & out_ready;
  assign out_data = head_r;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BUF_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next occupancy from push/pop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BUF_EMPTY: begin
        if (push_s) state_next_s = BUF_ONE;
        else        state_next_s = BUF_EMPTY;
      end
      BUF_ONE: begin
        if (push_s && !pop_s)      state_next_s = BUF_FULL;
        else if (pop_s && !push_s) state_next_s = BUF_EMPTY;
        else                       state_next_s = BUF_ONE;
      end
      BUF_FULL: begin
        if (pop_s) state_next_s = BUF_ONE;
        else       state_next_s = BUF_FULL;
      end
      default: state_next_s = BUF_EMPTY;
    endcase
  end

  // Handshake outputs decoded from the occupancy register.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      BUF_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      BUF_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      BUF_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Entry storage: head is always the oldest entry, tail only used when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
      tail_r <= '0;
    end else begin
      case (state_r)
        BUF_EMPTY: if (push_s) head_r <= in_data;
        BUF_ONE: begin
          if (push_s && pop_s) head_r <= in_data;
          else if (push_s)     tail_r <= in_data;
        end
        BUF_FULL:  if (pop_s) head_r <= tail_r;
        default: begin
          head_r <= head_r;
          tail_r <= tail_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: alu result capture, flag register, stall counter and rd==0 masking.
// Optional operand forwarding of the head entry is enabled by defining ALU_WB_FWD_EN.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int STALL_W = DEF_STALL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic              in_zero,
  input  logic              in_sign,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_setflags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              flag_zero,
  output logic              flag_sign,
  output logic [STALL_W-1:0] stall_cnt,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_x
);

  localparam int ENT_W = DATA_W + REG_AW + 1;

  logic [ENT_W-1:0]   in_ent_s;
  logic [ENT_W-1:0]   head_ent_s;
  logic               head_we_s;
  logic               push_s;
  logic               flag_zero_r;
  logic               flag_sign_r;
  logic [STALL_W-1:0] stall_r;

  // Entry layout {x, rd, we}.
  assign in_ent_s = {in_x, in_rd, in_we};

  alu_skid_buf #(
    .W (ENT_W)
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_ent_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_ent_s)
  );

  assign {out_x, out_rd, head_we_s} = head_ent_s;
  assign out_we    = head_we_s & (out_rd != {REG_AW{1'b0}});
  assign push_s    = in_valid & in_ready;
  assign flag_zero = flag_zero_r;
  assign flag_sign = flag_sign_r;
  assign stall_cnt = stall_r;

  // Architectural flags follow accepted entries in program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero_r <= 1'b0;
      flag_sign_r <= 1'b0;
    end else if (push_s && in_setflags) begin
      flag_zero_r <= in_zero;
      flag_sign_r <= in_sign;
    end else begin
      flag_zero_r <= flag_zero_r;
      flag_sign_r <= flag_sign_r;
    end
  end

  // Saturating count of upstream cycles refused by a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= {STALL_W{1'b0}};
    end else if (in_valid && !in_ready && (stall_r != {STALL_W{1'b1}})) begin
      stall_r <= stall_r + STALL_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

`ifdef ALU_WB_FWD_EN
  assign fwd_valid = out_valid & out_we;
  assign fwd_rd    = out_rd;
  assign fwd_x     = out_x;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = {REG_AW{1'b0}};
  assign fwd_x     = {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed steps then random traffic,
// compared each cycle against a queue-based reference model.
module tb_alu_wb_stage;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int SW  = 4;
  localparam int SAT = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_x;
  logic          in_zero, in_sign;
  logic [AW-1:0] in_rd;
  logic          in_we, in_setflags;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_x;
  logic [AW-1:0] out_rd;
  logic          out_we;
  logic          flag_zero, flag_sign;
  logic [SW-1:0] stall_cnt;
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_x;

  always #5 clk = ~clk;

  alu_wb_stage #(.DATA_W(DW), .REG_AW(AW), .STALL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_zero(in_zero), .in_sign(in_sign), .in_rd(in_rd),
    .in_we(in_we), .in_setflags(in_setflags),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_rd(out_rd), .out_we(out_we),
    .flag_zero(flag_zero), .flag_sign(flag_sign), .stall_cnt(stall_cnt),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_x(fwd_x)
  );

  typedef struct {
    logic [DW-1:0] x;
    logic [AW-1:0] rd;
    logic          we;
  } ent_t;

  ent_t mq[$];
  logic m_z, m_s;
  int   m_stall;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_z = 1'b0;
    m_s = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_all();
    logic hv, hwe;
    hv  = (mq.size() != 0);
    hwe = hv && mq[0].we && (mq[0].rd != 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, hv);
    if (hv) begin
      chk("out_x", out_x, mq[0].x);
      chk("out_rd", out_rd, mq[0].rd);
      chk("out_we", out_we, hwe);
    end
    chk("flag_zero", flag_zero, m_z);
    chk("flag_sign", flag_sign, m_s);
    chk("stall_cnt", stall_cnt, m_stall);
`ifdef ALU_WB_FWD_EN
    chk("fwd_valid", fwd_valid, hwe);
    if (hv) begin
      chk("fwd_rd", fwd_rd, mq[0].rd);
      chk("fwd_x", fwd_x, mq[0].x);
    end
`else
    chk("fwd_valid", fwd_valid, 1'b0);
    chk("fwd_rd", fwd_rd, 0);
    chk("fwd_x", fwd_x, 0);
`endif
  endtask

  // Check outputs, then advance one clock while applying the model's rules.
  task automatic step();
    bit push, pop;
    ent_t e;
    check_all();
    push = in_valid && (mq.size() < 2);
    pop  = (mq.size() != 0) && out_ready;
    e.x = in_x; e.rd = in_rd; e.we = in_we;
    @(posedge clk);
    if (in_valid && !push && m_stall < SAT) m_stall++;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(e);
      if (in_setflags) begin
        m_z = in_zero;
        m_s = in_sign;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] x, input logic [AW-1:0] rd,
                       input logic we, input logic sf, input logic z, input logic s,
                       input logic ordy);
    in_valid = v; in_x = x; in_rd = rd; in_we = we;
    in_setflags = sf; in_zero = z; in_sign = s; out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_we", out_we, 1'b0);
    chk("rst_flags", {flag_zero, flag_sign}, 2'b00);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_fwd", {fwd_valid, fwd_rd, fwd_x}, 0);
    rst_n = 1'b1;
    step();

    // Single push, one-cycle latency
    drive(1'b1, 32'd1234, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_x", out_x, 32'd1234);
    chk("lat_we", out_we, 1'b1);
    step();

    // Back-pressure: fill, stall a third entry, then drain in order
    drive(1'b1, 32'd5678, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_in_ready", in_ready, 1'b0);
    drive(1'b1, 32'd99, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("stall_3", stall_cnt, 3);
    chk("held_head", out_x, 32'd5678);
    drive(1'b1, 32'd99, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("order_2nd", out_x, 32'd3);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("order_3rd", out_x, 32'd99);
    step();

    // rd==0 never writes
    drive(1'b1, 32'h82345671, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rd0_we", out_we, 1'b0);
    step();

    // Flags only change on setflags pushes
    drive(1'b1, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h80000000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flags_hold", {flag_zero, flag_sign}, 2'b10);
    repeat (2) step();

    // Stall counter saturates
    drive(1'b1, 32'd42, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (SAT + 6) step();
    chk("stall_sat", stall_cnt, SAT);

    // Asynchronous reset with a full buffer
    chk("pre_rst_full", out_valid && !in_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_ready", in_ready, 1'b1);
    chk("async_stall", stall_cnt, 0);
    model_reset();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, AW'($urandom_range(0, 31)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0);
      step();
    end
    drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
